xgmii_frame_gen: RTL and testbench
==================================

// Module: xgmii_frame_gen
// PURPOSE
//  Test-frame generator upstream of the XAUI core TX XGMII interface, in the 156.25 MHz core clock domain.
//  Emits 64-bit/8-ctl XGMII columns: idle, start+preamble, sequence-stamped payload, terminate, inter-frame gap.
//  Runs continuously or for a fixed frame count. In loopback, feeds the RX checker via the XAUI lanes.
// PARAMETERS
//  MIN_LEN   64    minimum payload bytes; frame_len below this is clamped up
//  MAX_LEN   9600  maximum payload bytes; frame_len above this is clamped down
//  MIN_IFG   12    minimum inter-frame gap bytes; ifg_len below this is clamped up
// PORTS
//  clk156       in   1   156.25 MHz core clock, all logic on rising edge
//  reset        in   1   asynchronous, active-high reset
//  enable       in   1   level; generate while high
//  frame_len    in   16  payload bytes per frame, sampled at frame start
//  ifg_len      in   8   inter-frame gap in bytes, sampled at frame start
//  frame_count  in   32  frames to send per enable session; 0 = continuous
//  xgmii_txd    out  64  XGMII TX data, lane0 = [7:0]
//  xgmii_txc    out  8   XGMII TX control, bit i for lane i
//  busy         out  1   high from start column through end of gap
//  done         out  1   1-cycle pulse when frame_count frames have been sent
//  frames_sent  out  32  frames completed since reset; wraps at 2^32
// BEHAVIOUR
//  Reset: one clock, asynchronous, active-high; asserting reset forces state IDLE immediately.
//   Reset values: txd = {8{8'h07}}, txc = 8'hFF, busy = 0, done = 0, frames_sent = 0, session count = 0.
//  All outputs are registered. The first column leaves the block one cycle after the FSM decision.
//  FSM:
//   IDLE -> PRE when enable=1 and the count is not exhausted.
//   PRE (1 column) -> DATA.
//   DATA -> TERM or GAP.
//   TERM (1 column) -> GAP.
//   GAP (N columns) -> PRE when enable=1 and the count is not exhausted; otherwise -> IDLE.
//  IDLE/GAP columns: txd = 07 in all lanes, txc = FF.
//  PRE column: txd = D5_55_55_55_55_55_55_FB (lane7..lane0), txc = 01. Start is always in lane 0.
//  Length sampling at PRE: L = clamp(frame_len, MIN_LEN, MAX_LEN); G = max(ifg_len, MIN_IFG).
//  Payload byte k (0-based):
//   k = 0..3: frame sequence number, big-endian; the first frame after reset is 0.
//   k >= 4: k[7:0].
//  DATA columns carry bytes 8c..8c+7, txc = 00. Column count = ceil(L/8).
//  Last DATA column, when L mod 8 = r != 0:
//   lanes 0..r-1 are data, lane r = FD, lanes above r = 07.
//   txc = ~((1<<r)-1) & 8'hFF. No TERM column follows; go to GAP.
//  When r = 0, TERM column follows: lane0 = FD, lanes1-7 = 07, txc = FF.
//  Gap: N = ceil(G/8) columns of idle after the column holding FD. N is at least 2.
//  frames_sent and the sequence number increment in the cycle the FD column is issued.
//  Session count: cleared on a rising edge of enable; increments with frames_sent.
//   With frame_count != 0, after the frame_count-th FD the block finishes GAP and goes to IDLE.
//   done pulses on the GAP->IDLE transition.
//   A new session requires enable to go low, then high again.
//  enable falling mid-frame: the current frame and its gap complete, then IDLE. Frames are never truncated.
//  Changes to frame_len/ifg_len mid-frame: ignored until the next PRE.
//  frame_count = 0: done never pulses.
//  busy = 1 in PRE, DATA, TERM, GAP; 0 in IDLE.
// STRUCTURE
//  xgmii_defs.vh, shared with the RX checker:
//   IDLE=8'h07, START=8'hFB, TERM=8'hFD, PREAMBLE=8'h55, SFD=8'hD5
//   FSM state encodings
//   idle column constant {8{8'h07}}
//  One sub-module, xgmii_tail_encode: combinational.
//   Inputs: r (3-bit) and the payload column.
//   Outputs: the merged data/FD/idle txd and txc for the last column.
//   Reused by the checker's reference model.
// TESTING
//  T1: reset held, then released; enable = 0 for 20 cycles -> txd = 0707..07, txc = FF, busy = 0, frames_sent = 0.
//  T2: frame_len = 64, ifg_len = 12, frame_count = 1, enable = 1.
//   -> PRE column FB/55/D5 with txc = 01.
//   -> 8 DATA columns; bytes 0-3 = 00000000, byte 4 = 04 ... byte 63 = 3F.
//   -> TERM column FD + 07s with txc = FF, then 2 GAP columns.
//   -> done pulses once; frames_sent = 1.
//  T3: frame_len = 67, frame_count = 0.
//   -> last DATA column: lanes0-2 data, lane3 = FD, lanes 4-7 = 07, txc = F8; no TERM column.
//   -> the second frame's sequence bytes = 00000001.
//  T4: frame_len = 10, ifg_len = 40.
//   -> frame is clamped to 64 bytes; gap = 5 idle columns between the FD column and the next FB.
//  T5: enable dropped in the 3rd DATA column -> frame completes normally with FD; then GAP, then IDLE; done stays 0.
//  T6: reset asserted mid-DATA, asynchronously between edges.
//   -> outputs are the idle column immediately; frames_sent = 0.
//   -> after release with enable = 1, the first frame carries sequence 0.

Source files
------------

// File: rtl/xgmii_frame_gen_pkg.sv
// Shared XGMII constants, generator FSM encoding and length helpers.
// Latency: n/a (declarations and pure functions only).
// Backpressure: n/a.
package xgmii_frame_gen_pkg;

  // XGMII control characters
  localparam logic [7:0] XGMII_IDLE     = 8'h07;
  localparam logic [7:0] XGMII_START    = 8'hFB;
  localparam logic [7:0] XGMII_TERM     = 8'hFD;
  localparam logic [7:0] XGMII_PREAMBLE = 8'h55;
  localparam logic [7:0] XGMII_SFD      = 8'hD5;

  // Whole-column constants, lane7..lane0
  localparam logic [63:0] IDLE_COL = {8{XGMII_IDLE}};
  localparam logic [63:0] PRE_COL  = {XGMII_SFD, {6{XGMII_PREAMBLE}}, XGMII_START};

  // Default generator limits
  localparam int DEF_MIN_LEN = 64;
  localparam int DEF_MAX_LEN = 9600;
  localparam int DEF_MIN_IFG = 12;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_PRE  = 3'd1,
    ST_DATA = 3'd2,
    ST_TERM = 3'd3,
    ST_GAP  = 3'd4
  } state_t;

  // Clamp a requested payload length into [lo, hi].
  function automatic logic [15:0] clamp_len(input logic [15:0] len,
                                            input logic [15:0] lo,
                                            input logic [15:0] hi);
    logic [15:0] v;
    v = len;
    if (len < lo) v = lo;
    else if (len > hi) v = hi;
    return v;
  endfunction

  // Index of the last DATA column: ceil(len/8) - 1.
  function automatic logic [10:0] last_col_idx(input logic [15:0] len);
    return 11'(((len + 16'd7) >> 3) - 16'd1);
  endfunction

  // Index of the last GAP column: ceil(max(ifg, min_ifg)/8) - 1.
  // Worst case ifg = 255 gives 32 columns, index 31, so 5 bits suffice.
  function automatic logic [4:0] gap_last_idx(input logic [7:0] ifg,
                                              input logic [7:0] min_ifg);
    logic [7:0] g;
    g = (ifg < min_ifg) ? min_ifg : ifg;
    return 5'(((9'(g) + 9'd7) >> 3) - 9'd1);
  endfunction

endpackage

// File: rtl/xgmii_frame_gen_if.sv
// Configuration and XGMII TX bundle between the frame generator and its user.
// Latency: n/a (wires only).
// Backpressure: none; XGMII TX is a free-running column stream.
//  master: generator side (takes config, drives txd/txc/status)
//  slave : user side (drives config, observes txd/txc/status)
interface xgmii_frame_gen_if;
  logic        enable;
  logic [15:0] frame_len;
  logic [7:0]  ifg_len;
  logic [31:0] frame_count;
  logic [63:0] xgmii_txd;
  logic [7:0]  xgmii_txc;
  logic        busy;
  logic        done;
  logic [31:0] frames_sent;

  modport master (
    input  enable, frame_len, ifg_len, frame_count,
    output xgmii_txd, xgmii_txc, busy, done, frames_sent
  );

  modport slave (
    output enable, frame_len, ifg_len, frame_count,
    input  xgmii_txd, xgmii_txc, busy, done, frames_sent
  );
endinterface

// File: rtl/xgmii_frame_gen_tail_encode.sv
// Builds the column carrying FD: lanes below r are payload, lane r is FD, lanes above are idle.
// Latency: combinational.
// Backpressure: none.
//  r       in  3   number of payload bytes in this column (0 = pure terminate column)
//  payload in  64  payload bytes for the column, lane0 = [7:0]
//  txd     out 64  merged data/FD/idle column
//  txc     out 8   control flags, set for the FD lane and every lane above it
module xgmii_frame_gen_tail_encode
  import xgmii_frame_gen_pkg::*;
(
  input  logic [2:0]  r,
  input  logic [63:0] payload,
  output logic [63:0] txd,
  output logic [7:0]  txc
);

  always_comb begin
    txd = IDLE_COL;
    txc = 8'hFF;
    for (int i = 0; i < 8; i++) begin
      if (3'(i) < r) begin
        txd[8*i +: 8] = payload[8*i +: 8];
        txc[i]        = 1'b0;
      end else if (3'(i) == r) begin
        txd[8*i +: 8] = XGMII_TERM;
        txc[i]        = 1'b1;
      end else begin
        txd[8*i +: 8] = XGMII_IDLE;
        txc[i]        = 1'b1;
      end
    end
  end

endmodule

// File: rtl/xgmii_frame_gen.sv
// XGMII test-frame generator: idle, start/preamble, sequence-stamped payload, terminate, gap.
// Latency: every output is registered; a column appears one clk156 after the FSM decides it.
// Backpressure: none; one column per cycle, frames always run to completion once started.
//  clk156, reset : core clock, asynchronous active-high reset
//  gen_if        : enable/frame_len/ifg_len/frame_count in; xgmii_txd/txc, busy, done, frames_sent out
module xgmii_frame_gen
  import xgmii_frame_gen_pkg::*;
#(
  parameter int MIN_LEN = DEF_MIN_LEN,
  parameter int MAX_LEN = DEF_MAX_LEN,
  parameter int MIN_IFG = DEF_MIN_IFG
) (
  input  logic              clk156,
  input  logic              reset,
  xgmii_frame_gen_if.master gen_if
);

  state_t state_q, state_d;

  logic [63:0] txd_q, txd_d;
  logic [7:0]  txc_q, txc_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;

  logic [31:0] frames_sent_q, frames_sent_d;
  logic [31:0] seq_q, seq_d;
  logic [31:0] sess_cnt_q, sess_cnt_d;
  logic        enable_q, enable_d;
  logic [10:0] col_q, col_d;
  logic [10:0] last_col_q, last_col_d;
  logic [2:0]  r_q, r_d;
  logic [4:0]  gap_q, gap_d;
  logic [4:0]  gap_last_q, gap_last_d;

  logic        enable_rise;
  logic [31:0] sess_base;
  logic        exhausted;
  logic        can_start;
  logic        last_data;
  logic        gap_end;
  logic        fd_issue;
  logic [15:0] len_clamped;

  logic [63:0] payload;
  logic [2:0]  tail_r;
  logic [63:0] tail_txd;
  logic [7:0]  tail_txc;

  // ---------------------------------------------------------------
  // Session / frame status
  // ---------------------------------------------------------------
  always_comb begin
    enable_rise = gen_if.enable & ~enable_q;
    // A rising enable opens a fresh session this very cycle, so the
    // start decision must not see the previous session's count.
    sess_base   = enable_rise ? 32'd0 : sess_cnt_q;
    exhausted   = (gen_if.frame_count != 32'd0) && (sess_base >= gen_if.frame_count);
    can_start   = gen_if.enable && !exhausted;
    last_data   = (state_q == ST_DATA) && (col_q == last_col_q);
    gap_end     = (state_q == ST_GAP) && (gap_q == gap_last_q);
    // FD goes out either in a partial last DATA column or in TERM.
    fd_issue    = (last_data && (r_q != 3'd0)) || (state_q == ST_TERM);
    len_clamped = clamp_len(gen_if.frame_len, 16'(MIN_LEN), 16'(MAX_LEN));
  end

  // ---------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------
  always_ff @(posedge clk156 or posedge reset) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // ---------------------------------------------------------------
  // FSM: next state
  // ---------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (can_start) state_d = ST_PRE;
      ST_PRE:  state_d = ST_DATA;
      ST_DATA: begin
        if (last_data) state_d = (r_q != 3'd0) ? ST_GAP : ST_TERM;
      end
      ST_TERM: state_d = ST_GAP;
      ST_GAP: begin
        if (gap_end) state_d = can_start ? ST_PRE : ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------
  // Payload column: bytes 0..3 are the big-endian sequence number,
  // every later byte k carries k[7:0] = {col[4:0], lane}.
  // ---------------------------------------------------------------
  always_comb begin
    payload = '0;
    for (int i = 0; i < 8; i++) begin
      payload[8*i +: 8] = {col_q[4:0], 3'(i)};
    end
    if (col_q == 11'd0) begin
      payload[31:0] = {seq_q[7:0], seq_q[15:8], seq_q[23:16], seq_q[31:24]};
    end
  end

  // TERM is the r = 0 case of the tail column: FD in lane 0, idles above.
  assign tail_r = (state_q == ST_TERM) ? 3'd0 : r_q;

  xgmii_frame_gen_tail_encode u_tail (
    .r       (tail_r),
    .payload (payload),
    .txd     (tail_txd),
    .txc     (tail_txc)
  );

  // ---------------------------------------------------------------
  // FSM: outputs (next column and status, registered below)
  // ---------------------------------------------------------------
  always_comb begin
    txd_d  = IDLE_COL;
    txc_d  = 8'hFF;
    busy_d = (state_q != ST_IDLE);
    done_d = gap_end && !can_start && exhausted;
    case (state_q)
      ST_PRE: begin
        txd_d = PRE_COL;
        txc_d = 8'h01;
      end
      ST_DATA: begin
        if (last_data && (r_q != 3'd0)) begin
          txd_d = tail_txd;
          txc_d = tail_txc;
        end else begin
          txd_d = payload;
          txc_d = 8'h00;
        end
      end
      ST_TERM: begin
        txd_d = tail_txd;
        txc_d = tail_txc;
      end
      default: begin
        txd_d = IDLE_COL;
        txc_d = 8'hFF;
      end
    endcase
  end

  // ---------------------------------------------------------------
  // Datapath: counters and per-frame sampled lengths
  // ---------------------------------------------------------------
  always_comb begin
    enable_d      = gen_if.enable;
    col_d         = col_q;
    last_col_d    = last_col_q;
    r_d           = r_q;
    gap_last_d    = gap_last_q;
    gap_d         = (state_q == ST_GAP) ? gap_q + 5'd1 : 5'd0;
    seq_d         = seq_q + {31'd0, fd_issue};
    frames_sent_d = frames_sent_q + {31'd0, fd_issue};
    sess_cnt_d    = sess_base + {31'd0, fd_issue};

    if (state_q == ST_PRE) begin
      // Lengths are frozen here for the whole frame and its gap.
      col_d      = 11'd0;
      last_col_d = last_col_idx(len_clamped);
      r_d        = len_clamped[2:0];
      gap_last_d = gap_last_idx(gen_if.ifg_len, 8'(MIN_IFG));
    end else if (state_q == ST_DATA) begin
      col_d = col_q + 11'd1;
    end
  end

  always_ff @(posedge clk156 or posedge reset) begin
    if (reset) begin
      txd_q         <= IDLE_COL;
      txc_q         <= 8'hFF;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      frames_sent_q <= 32'd0;
      seq_q         <= 32'd0;
      sess_cnt_q    <= 32'd0;
      enable_q      <= 1'b0;
      col_q         <= 11'd0;
      last_col_q    <= 11'd0;
      r_q           <= 3'd0;
      gap_q         <= 5'd0;
      gap_last_q    <= 5'd0;
    end else begin
      txd_q         <= txd_d;
      txc_q         <= txc_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      frames_sent_q <= frames_sent_d;
      seq_q         <= seq_d;
      sess_cnt_q    <= sess_cnt_d;
      enable_q      <= enable_d;
      col_q         <= col_d;
      last_col_q    <= last_col_d;
      r_q           <= r_d;
      gap_q         <= gap_d;
      gap_last_q    <= gap_last_d;
    end
  end

  assign gen_if.xgmii_txd   = txd_q;
  assign gen_if.xgmii_txc   = txc_q;
  assign gen_if.busy        = busy_q;
  assign gen_if.done        = done_q;
  assign gen_if.frames_sent = frames_sent_q;

endmodule

// File: tb/tb_xgmii_frame_gen.sv
module tb_xgmii_frame_gen;

  localparam logic [63:0] C_IDLE = 64'h0707070707070707;
  localparam logic [63:0] C_PRE  = 64'hD5555555555555FB;
  localparam logic [63:0] C_TERM = 64'h07070707070707FD;
  localparam logic [63:0] C_T67  = 64'h07070707FD424140;

  logic clk = 1'b0;
  logic rst;
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  xgmii_frame_gen_if u_if ();

  xgmii_frame_gen dut (
    .clk156 (clk),
    .reset  (rst),
    .gen_if (u_if)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_col(input string tag, input logic [63:0] txd, input logic [7:0] txc,
                         input logic busy);
    chk({tag, "_txd"}, u_if.xgmii_txd, txd);
    chk({tag, "_txc"}, {56'd0, u_if.xgmii_txc}, {56'd0, txc});
    chk({tag, "_busy"}, {63'd0, u_if.busy}, {63'd0, busy});
  endtask

  // Expected payload column c of a frame carrying sequence number seq.
  function automatic logic [63:0] exp_dcol(input logic [31:0] seq, input int c);
    logic [63:0] v;
    for (int i = 0; i < 8; i++) v[8*i +: 8] = 8'(8*c + i);
    if (c == 0) begin
      v[7:0]   = seq[31:24];
      v[15:8]  = seq[23:16];
      v[23:16] = seq[15:8];
      v[31:24] = seq[7:0];
    end
    return v;
  endfunction

  task automatic data_cols(input string tag, input logic [31:0] seq, input int first,
                           input int last);
    for (int c = first; c <= last; c++) begin
      tick();
      chk_col($sformatf("%s_c%0d", tag, c), exp_dcol(seq, c), 8'h00, 1'b1);
    end
  endtask

  task automatic gap_cols(input string tag, input int n);
    for (int g = 0; g < n; g++) begin
      tick();
      chk_col($sformatf("%s_g%0d", tag, g), C_IDLE, 8'hFF, 1'b1);
      chk($sformatf("%s_g%0d_done", tag, g), {63'd0, u_if.done}, 64'd0);
    end
  endtask

  task automatic wait_pre(input string tag);
    bit found;
    found = 1'b0;
    for (int i = 0; i < 64 && !found; i++) begin
      tick();
      if (u_if.xgmii_txd === C_PRE && u_if.xgmii_txc === 8'h01) found = 1'b1;
    end
    chk({tag, "_found"}, {63'd0, found}, 64'd1);
  endtask

  initial begin
    rst               = 1'b1;
    u_if.enable       = 1'b0;
    u_if.frame_len    = 16'd64;
    u_if.ifg_len      = 8'd12;
    u_if.frame_count  = 32'd0;

    // T1: reset state, then idle while disabled
    repeat (3) tick();
    chk_col("t1_rst", C_IDLE, 8'hFF, 1'b0);
    chk("t1_rst_done", {63'd0, u_if.done}, 64'd0);
    chk("t1_rst_fs", {32'd0, u_if.frames_sent}, 64'd0);
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      chk_col($sformatf("t1_idle%0d", i), C_IDLE, 8'hFF, 1'b0);
    end
    chk("t1_fs", {32'd0, u_if.frames_sent}, 64'd0);

    // T2: one 64-byte frame, exact start latency, TERM, 2 gap columns, done
    u_if.frame_count = 32'd1;
    u_if.enable      = 1'b1;
    tick();
    chk_col("t2_lat", C_IDLE, 8'hFF, 1'b0);
    tick();
    chk_col("t2_pre", C_PRE, 8'h01, 1'b1);
    data_cols("t2", 32'd0, 0, 7);
    tick();
    chk_col("t2_term", C_TERM, 8'hFF, 1'b1);
    chk("t2_term_fs", {32'd0, u_if.frames_sent}, 64'd1);
    tick();
    chk_col("t2_g0", C_IDLE, 8'hFF, 1'b1);
    chk("t2_g0_done", {63'd0, u_if.done}, 64'd0);
    tick();
    chk_col("t2_g1", C_IDLE, 8'hFF, 1'b1);
    chk("t2_g1_done", {63'd0, u_if.done}, 64'd1);
    tick();
    chk_col("t2_idle", C_IDLE, 8'hFF, 1'b0);
    chk("t2_idle_done", {63'd0, u_if.done}, 64'd0);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk_col($sformatf("t2_hold%0d", i), C_IDLE, 8'hFF, 1'b0);
    end
    chk("t2_fs", {32'd0, u_if.frames_sent}, 64'd1);
    u_if.enable = 1'b0;
    tick();

    // T3: 67-byte frames, continuous; partial tail column, no TERM
    rst = 1'b1;
    tick();
    rst = 1'b0;
    u_if.frame_len   = 16'd67;
    u_if.ifg_len     = 8'd12;
    u_if.frame_count = 32'd0;
    u_if.enable      = 1'b1;
    wait_pre("t3_pre1");
    data_cols("t3f1", 32'd0, 0, 7);
    tick();
    chk_col("t3f1_tail", C_T67, 8'hF8, 1'b1);
    chk("t3f1_fs", {32'd0, u_if.frames_sent}, 64'd1);
    gap_cols("t3f1", 2);
    tick();
    chk_col("t3_pre2", C_PRE, 8'h01, 1'b1);
    // New lengths arrive mid-frame: frame 2 and its gap must not change.
    u_if.frame_len = 16'd10;
    u_if.ifg_len   = 8'd40;
    data_cols("t3f2", 32'd1, 0, 7);
    tick();
    chk_col("t3f2_tail", C_T67, 8'hF8, 1'b1);
    gap_cols("t3f2", 2);
    tick();
    chk_col("t4_pre", C_PRE, 8'h01, 1'b1);

    // T4: length 10 clamped to 64, ifg 40 gives 5 gap columns
    data_cols("t4", 32'd2, 0, 7);
    tick();
    chk_col("t4_term", C_TERM, 8'hFF, 1'b1);
    gap_cols("t4", 5);
    tick();
    chk_col("t5_pre", C_PRE, 8'h01, 1'b1);

    // T5: enable drops in the 3rd DATA column; frame and gap still complete
    data_cols("t5", 32'd3, 0, 2);
    u_if.enable = 1'b0;
    data_cols("t5", 32'd3, 3, 7);
    tick();
    chk_col("t5_term", C_TERM, 8'hFF, 1'b1);
    gap_cols("t5", 5);
    tick();
    chk_col("t5_idle", C_IDLE, 8'hFF, 1'b0);
    chk("t5_idle_done", {63'd0, u_if.done}, 64'd0);
    chk("t5_fs", {32'd0, u_if.frames_sent}, 64'd4);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_col($sformatf("t5_hold%0d", i), C_IDLE, 8'hFF, 1'b0);
    end

    // T6: asynchronous reset in the middle of DATA
    u_if.frame_len = 16'd64;
    u_if.ifg_len   = 8'd12;
    u_if.enable    = 1'b1;
    wait_pre("t6_pre1");
    data_cols("t6a", 32'd4, 0, 1);
    #2;
    rst = 1'b1;
    #1;
    chk_col("t6_async", C_IDLE, 8'hFF, 1'b0);
    chk("t6_async_fs", {32'd0, u_if.frames_sent}, 64'd0);
    tick();
    rst = 1'b0;
    wait_pre("t6_pre2");
    data_cols("t6b", 32'd0, 0, 0);
    chk("t6_fs", {32'd0, u_if.frames_sent}, 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
